// File: rtl/dice_pkg.sv
// Shared definitions for the dice_multi_roll custom instruction.
// Covers die codes, face/mask lookups, FSM states and result-word field positions.
package dice_pkg;

    localparam int unsigned CI_W       = 32;
    localparam int unsigned CODE_W     = 4;
    localparam int unsigned DIE_W      = 7;
    localparam int unsigned MOD_W      = 8;

    localparam logic [CODE_W-1:0] DIE_D4      = 4'd0;
    localparam logic [CODE_W-1:0] DIE_D6      = 4'd1;
    localparam logic [CODE_W-1:0] DIE_D8      = 4'd2;
    localparam logic [CODE_W-1:0] DIE_D10     = 4'd3;
    localparam logic [CODE_W-1:0] DIE_D12     = 4'd4;
    localparam logic [CODE_W-1:0] DIE_D20     = 4'd5;
    localparam logic [CODE_W-1:0] DIE_D100    = 4'd6;
    localparam logic [CODE_W-1:0] DIE_INVALID = 4'd7;

    localparam int unsigned RES_SUM_LSB = 0;
    localparam int unsigned RES_SUM_W   = 16;
    localparam int unsigned RES_MAX_LSB = 16;
    localparam int unsigned RES_MIN_LSB = 23;
    localparam int unsigned RES_ERR_BIT = 31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2,
        ST_FINISH  = 2'd3
    } state_t;

    function automatic logic [DIE_W-1:0] die_faces(input logic [CODE_W-1:0] code);
        logic [DIE_W-1:0] f;
        unique case (code)
            DIE_D4:   f = 7'd4;
            DIE_D6:   f = 7'd6;
            DIE_D8:   f = 7'd8;
            DIE_D10:  f = 7'd10;
            DIE_D12:  f = 7'd12;
            DIE_D20:  f = 7'd20;
            DIE_D100: f = 7'd100;
            default:  f = 7'd0;
        endcase
        return f;
    endfunction

    // Smallest all-ones mask covering faces-1, so rejections stay below 50%.
    function automatic logic [DIE_W-1:0] die_mask(input logic [CODE_W-1:0] code);
        logic [DIE_W-1:0] m;
        unique case (code)
            DIE_D4:   m = 7'd3;
            DIE_D6:   m = 7'd7;
            DIE_D8:   m = 7'd7;
            DIE_D10:  m = 7'd15;
            DIE_D12:  m = 7'd15;
            DIE_D20:  m = 7'd31;
            DIE_D100: m = 7'd127;
            default:  m = 7'd0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dice_multi_roll_if.sv
// Nios custom-instruction handshake bundle for dice_multi_roll.
interface dice_multi_roll_if;
    import dice_pkg::*;

    logic            clk_en;
    logic            start;
    logic [CI_W-1:0] dataa;
    logic [CI_W-1:0] datab;
    logic [CI_W-1:0] result;
    logic            done;

    modport master (output clk_en, start, dataa, datab, input result, done);
    modport slave  (input clk_en, start, dataa, datab, output result, done);

endinterface

// File: rtl/rng_bit_sipo.sv
// MSB-first serial-to-parallel collector for the entropy bit stream.
module rng_bit_sipo #(
    parameter int unsigned RAND_W = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [RAND_W-1:0] sample,
    output logic              sample_ready_c
);

    localparam int unsigned CNT_W = $clog2(RAND_W + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample <= '0;
            count  <= '0;
        end else if (clear) begin
            sample <= '0;
            count  <= '0;
        end else if (shift_en) begin
            sample <= {sample[RAND_W-2:0], bit_in};
            count  <= count + CNT_W'(1);
        end
    end

    // High when the bit being shifted this cycle completes the sample.
    assign sample_ready_c = shift_en && (count == CNT_W'(RAND_W - 1));

endmodule

// File: rtl/dice_multi_roll.sv
// Multi-dice roll custom instruction: rejection-sampled dice from serial entropy plus modifier.
// Define DICE_ROLL_STATS_EN to add per-instruction min/max die tracking in result[29:16].
module dice_multi_roll
    import dice_pkg::*;
#(
    parameter int unsigned RAND_W   = 7,
    parameter int unsigned MAX_DICE = 8,
    parameter int unsigned SUM_W    = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    dice_multi_roll_if.slave   ci,
    input  logic               i_rand_bit,
    input  logic               i_rand_valid,
    output logic               o_stop
);

    localparam int unsigned TOT_W = SUM_W + 1;

    state_t            state;
    logic [CODE_W-1:0] die_code;
    logic [3:0]        dice_left;
    logic [MOD_W-1:0]  modifier;
    logic [SUM_W-1:0]  acc;
    logic [CI_W-1:0]   result_q;
    logic              done_q;
    logic              stop_q;

    logic [RAND_W-1:0] sample;
    logic              sample_ready_c;
    logic              shift_en_c;
    logic              clear_c;
    logic              req_err_c;
    logic [RAND_W-1:0] v_c;
    logic              accept_c;
    logic [DIE_W-1:0]  die_c;
    logic [SUM_W-1:0]  acc_next_c;
    logic signed [TOT_W-1:0] total_c;
    logic [CI_W-1:0]   final_word_c;
    logic              unused_bits_c;

`ifdef DICE_ROLL_STATS_EN
    logic [DIE_W-1:0]  max_q;
    logic [DIE_W-1:0]  min_q;
    logic [DIE_W-1:0]  max_next_c;
    logic [DIE_W-1:0]  min_next_c;
`endif

    assign shift_en_c = ci.clk_en && (state == ST_COLLECT) && i_rand_valid;
    assign clear_c    = ci.clk_en && (((state == ST_IDLE) && ci.start) || (state == ST_CHECK));

    rng_bit_sipo #(.RAND_W(RAND_W)) u_sipo (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (clear_c),
        .shift_en       (shift_en_c),
        .bit_in         (i_rand_bit),
        .sample         (sample),
        .sample_ready_c (sample_ready_c)
    );

    assign unused_bits_c = ^{ci.dataa[CI_W-1:8], ci.datab[CI_W-1:8]};

    assign req_err_c = (ci.dataa[3:0] >= DIE_INVALID) ||
                       (ci.dataa[7:4] == 4'd0)        ||
                       (ci.dataa[7:4] > 4'(MAX_DICE));

    // Rejection sampling and running-sum datapath.
    always_comb begin
        v_c        = sample & RAND_W'(die_mask(die_code));
        accept_c   = v_c < RAND_W'(die_faces(die_code));
        die_c      = DIE_W'(v_c) + 7'd1;
        acc_next_c = acc + SUM_W'(die_c);
        total_c    = $signed({1'b0, acc_next_c}) +
                     $signed({{(TOT_W-MOD_W){modifier[MOD_W-1]}}, modifier});
    end

`ifdef DICE_ROLL_STATS_EN
    assign max_next_c = (die_c > max_q) ? die_c : max_q;
    assign min_next_c = (die_c < min_q) ? die_c : min_q;
`endif

    // Result word for the final accepted die; negative totals clamp to zero.
    always_comb begin
        final_word_c = '0;
        if (!total_c[TOT_W-1]) begin
            final_word_c[RES_SUM_LSB +: RES_SUM_W] = RES_SUM_W'(total_c[TOT_W-2:0]);
        end
`ifdef DICE_ROLL_STATS_EN
        final_word_c[RES_MAX_LSB +: DIE_W] = max_next_c;
        final_word_c[RES_MIN_LSB +: DIE_W] = min_next_c;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            die_code  <= '0;
            dice_left <= '0;
            modifier  <= '0;
            acc       <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            stop_q    <= 1'b1;
`ifdef DICE_ROLL_STATS_EN
            max_q     <= '0;
            min_q     <= '0;
`endif
        end else if (!ci.clk_en) begin
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    stop_q <= 1'b1;
                    if (ci.start) begin
                        die_code  <= ci.dataa[3:0];
                        dice_left <= ci.dataa[7:4];
                        modifier  <= ci.datab[MOD_W-1:0];
                        acc       <= '0;
`ifdef DICE_ROLL_STATS_EN
                        max_q     <= '0;
                        min_q     <= '1;
`endif
                        if (req_err_c) begin
                            state    <= ST_FINISH;
                            done_q   <= 1'b1;
                            result_q <= CI_W'(1) << RES_ERR_BIT;
                        end else begin
                            state  <= ST_COLLECT;
                            stop_q <= 1'b0;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (sample_ready_c) state <= ST_CHECK;
                end
                ST_CHECK: begin
                    state <= ST_COLLECT;
                    if (accept_c) begin
                        acc       <= acc_next_c;
                        dice_left <= dice_left - 4'd1;
`ifdef DICE_ROLL_STATS_EN
                        max_q     <= max_next_c;
                        min_q     <= min_next_c;
`endif
                        if (dice_left == 4'd1) begin
                            state    <= ST_FINISH;
                            done_q   <= 1'b1;
                            result_q <= final_word_c;
                            stop_q   <= 1'b1;
                        end
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ci.result = result_q;
    assign ci.done   = done_q;
    assign o_stop    = stop_q;

endmodule

// File: tb/tb_dice_multi_roll.sv
// Directed self-checking bench for dice_multi_roll (optionally built with DICE_ROLL_STATS_EN).
module tb_dice_multi_roll;

    localparam int unsigned RAND_W = 7;
    localparam int NO_EVENT = 100000;

`ifdef DICE_ROLL_STATS_EN
    localparam logic [31:0] EXP_D6     = 32'h0183_0003;
    localparam logic [31:0] EXP_D20X3  = 32'h0094_001A;
    localparam logic [31:0] EXP_CLAMP0 = 32'h0081_0000;
    localparam logic [31:0] EXP_CLAMP6 = 32'h0081_0006;
    localparam logic [31:0] EXP_D100   = 32'h3264_00E3;
    localparam logic [31:0] EXP_D4X8   = 32'h0204_0020;
`else
    localparam logic [31:0] EXP_D6     = 32'h0000_0003;
    localparam logic [31:0] EXP_D20X3  = 32'h0000_001A;
    localparam logic [31:0] EXP_CLAMP0 = 32'h0000_0000;
    localparam logic [31:0] EXP_CLAMP6 = 32'h0000_0006;
    localparam logic [31:0] EXP_D100   = 32'h0000_00E3;
    localparam logic [31:0] EXP_D4X8   = 32'h0000_0020;
`endif
    localparam logic [31:0] EXP_ERR    = 32'h8000_0000;

    logic clk;
    logic reset_n;
    logic i_rand_bit;
    logic i_rand_valid;
    logic o_stop;

    int checks;
    int failures;

    dice_multi_roll_if ci();

    dice_multi_roll dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ci           (ci),
        .i_rand_bit   (i_rand_bit),
        .i_rand_valid (i_rand_valid),
        .o_stop       (o_stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One instruction: start at cycle 0, feed bits only in COLLECT cycles (one idle cycle
    // after every RAND_W bits for CHECK), optional valid gaps, clk_en stall and busy start.
    task automatic roll(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] bits, input int nbits, input bit gaps,
                        input int stall_at, input int busy_at,
                        input logic [31:0] exp_res, input int exp_lat);
        int cyc;
        int k;
        int grp;
        int first_done;
        int done_cnt;
        int stop_early;
        logic [31:0] res_at_done;
        logic stop_at_done;
        cyc = 0; k = 0; grp = 0; first_done = -1; done_cnt = 0; stop_early = 0;
        res_at_done = '0; stop_at_done = 1'b0;

        @(negedge clk);
        ci.dataa = a; ci.datab = b; ci.start = 1'b1; i_rand_valid = 1'b0;
        while (cyc < 400 && !(first_done >= 0 && cyc >= first_done + 3)) begin
            @(negedge clk);
            cyc++;
            if (ci.done) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done   = cyc;
                    res_at_done  = ci.result;
                    stop_at_done = o_stop;
                end
            end else if (first_done < 0 && o_stop) begin
                stop_early++;
            end
            ci.start     = (cyc == busy_at);
            ci.dataa     = (cyc == busy_at) ? 32'h0000_0006 : a;
            ci.clk_en    = 1'b1;
            i_rand_valid = 1'b0;
            i_rand_bit   = 1'b0;
            if (cyc >= stall_at && cyc < stall_at + 10) begin
                ci.clk_en    = 1'b0;
                i_rand_valid = 1'b1;
                i_rand_bit   = 1'b1;
            end else if (k < nbits) begin
                if (grp == RAND_W) begin
                    grp = 0;
                end else if (gaps && (cyc % 3 == 0)) begin
                    i_rand_bit = 1'b1;
                end else begin
                    i_rand_valid = 1'b1;
                    i_rand_bit   = bits[nbits-1-k];
                    k++;
                    grp++;
                end
            end
        end
        ci.start = 1'b0; ci.clk_en = 1'b1; i_rand_valid = 1'b0;

        check_eq({tag, " done_seen"}, 32'(first_done >= 0), 32'd1);
        check_eq({tag, " result"}, res_at_done, exp_res);
        check_eq({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        check_eq({tag, " stop_at_done"}, 32'(stop_at_done), 32'd1);
        check_eq({tag, " stop_high_busy"}, 32'(stop_early), 32'd0);
        check_eq({tag, " result_held"}, ci.result, exp_res);
        if (exp_lat >= 0) check_eq({tag, " latency"}, 32'(first_done), 32'(exp_lat));
    endtask

    initial begin
        int dn;
        checks = 0; failures = 0;
        reset_n = 1'b0; ci.clk_en = 1'b1; ci.start = 1'b0;
        ci.dataa = '0; ci.datab = '0; i_rand_bit = 1'b0; i_rand_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset result", ci.result, 32'h0);
        check_eq("reset done", 32'(ci.done), 32'd0);
        check_eq("reset stop", 32'(o_stop), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        roll("d6_reject", 32'h11, 32'h00, 64'b0000111_0000010, 14, 1'b0,
             NO_EVENT, NO_EVENT, EXP_D6, 17);
        roll("d20x3", 32'h35, 32'h00, 64'b0000000_0010011_0000100, 21, 1'b0,
             NO_EVENT, NO_EVENT, EXP_D20X3, 25);
        roll("err_code", 32'h1F, 32'h00, 64'h0, 0, 1'b0, NO_EVENT, NO_EVENT, EXP_ERR, 1);
        roll("err_cnt0", 32'h01, 32'h00, 64'h0, 0, 1'b0, NO_EVENT, NO_EVENT, EXP_ERR, 1);
        roll("err_cnt9", 32'h95, 32'h00, 64'h0, 0, 1'b0, NO_EVENT, NO_EVENT, EXP_ERR, 1);
        roll("clamp_neg", 32'h10, 32'hFE, 64'b0000000, 7, 1'b0,
             NO_EVENT, NO_EVENT, EXP_CLAMP0, 9);
        roll("mod_pos", 32'h10, 32'h05, 64'b0000000, 7, 1'b0,
             NO_EVENT, NO_EVENT, EXP_CLAMP6, 9);
        roll("stall", 32'h35, 32'h00, 64'b0000000_0010011_0000100, 21, 1'b0,
             4, NO_EVENT, EXP_D20X3, 35);
        roll("gaps", 32'h35, 32'h00, 64'b0000000_0010011_0000100, 21, 1'b1,
             NO_EVENT, NO_EVENT, EXP_D20X3, -1);
        roll("busy_start", 32'h11, 32'h00, 64'b0000010, 7, 1'b0,
             NO_EVENT, 3, EXP_D6, 9);
        roll("d100_mod", 32'h16, 32'h7F, 64'b1100011, 7, 1'b0,
             NO_EVENT, NO_EVENT, EXP_D100, 9);

        // Reset in the middle of COLLECT abandons the roll.
        @(negedge clk);
        ci.dataa = 32'h11; ci.datab = 32'h0; ci.start = 1'b1;
        @(negedge clk);
        ci.start = 1'b0; i_rand_valid = 1'b1; i_rand_bit = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("midreset result", ci.result, 32'h0);
        check_eq("midreset stop", 32'(o_stop), 32'd1);
        check_eq("midreset done", 32'(ci.done), 32'd0);
        dn = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (ci.done) dn++;
        end
        i_rand_valid = 1'b0;
        check_eq("midreset no_done", 32'(dn), 32'd0);

        roll("d4x8", 32'h80, 32'h00, {8{7'b0000011}}, 56, 1'b0,
             NO_EVENT, NO_EVENT, EXP_D4X8, 65);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dice_multi_roll.md
Name: dice_multi_roll

Overview:
- Next-generation dice-roll custom instruction for the Nios core.
- Consumes a serial entropy bit stream from the ring-oscillator source and uses rejection sampling to produce unbiased die values.
- Rolls up to MAX_DICE dice of one selectable type and adds a signed modifier.
- Returns the total, plus optional min/max statistics, over the standard start/done custom-instruction handshake.

Parameters:
- RAND_W, 7: bits collected per sample attempt. Must be ≥7 so the D100 range is reachable.
- MAX_DICE, 8: largest legal dice count per instruction (1..15).
- SUM_W, 16: internal accumulator width. Must hold MAX_DICE*100+127.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- clk_en  in  1  custom-instruction clock enable; when low, all state is frozen.
- start  in  1  instruction start; sampled only when clk_en=1.
- dataa  in  32  [3:0] die code, [7:4] dice count, [31:8] ignored.
- datab  in  32  [7:0] signed two's-complement modifier, [31:8] ignored.
- result  out  32  roll result word, defined under Behaviour.
- done  out  1  one-cycle completion pulse.
- i_rand_bit  in  1  entropy bit.
- i_rand_valid  in  1  i_rand_bit is valid this cycle.
- o_stop  out  1  high = entropy source may halt.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; result=0, done=0, o_stop=1; accumulator, counters and shift register cleared. Reset mid-operation abandons the roll and produces no done.
- Die codes: 0=D4, 1=D6, 2=D8, 3=D10, 4=D12, 5=D20, 6=D100; codes 7..15 are invalid. Faces mask = smallest 2^k−1 ≥ faces−1 (D4:3, D6:7, D8:7, D10:15, D12:15, D20:31, D100:127).
- FSM states: IDLE, COLLECT, CHECK, FINISH. All transitions are gated by clk_en.
- IDLE:
  - o_stop=1.
  - On start: latch die code, count and modifier; clear the accumulator.
  - Invalid code, count=0 or count>MAX_DICE → FINISH with error.
  - Otherwise → COLLECT.
- COLLECT:
  - o_stop=0.
  - Each cycle with i_rand_valid=1, shift i_rand_bit in MSB-first and increment the bit counter.
  - After RAND_W bits → CHECK.
  - Cycles with i_rand_valid=0 add no bit.
- CHECK:
  - Compute v = sample & mask.
  - If v < faces: accept; die = v+1; add it to the accumulator; decrement dice remaining. Go to FINISH if none remain, else to COLLECT.
  - If v ≥ faces: reject and return to COLLECT with the bit counter cleared.
- FINISH:
  - done=1 for exactly this cycle; result is registered on entry; → IDLE.
  - Result is held until the next accepted start.
- Result word:
  - result[15:0] = max(0, sum + sign-extended modifier).
  - result[31] = error flag. On error, all other bits are 0.
  - Bits not used by the optional feature are 0.
- Latency:
  - Error path: start at cycle N, done at N+1.
  - Valid roll with continuous valid bits, no rejections: count*(RAND_W+1)+1 cycles from start to done.
- start while not in IDLE is ignored, including during FINISH.
- clk_en=0 holds the state, counters and shift register, and holds done low. i_rand_valid is ignored while clk_en=0.

Optional Feature:
- Macro: DICE_ROLL_STATS_EN.
- When defined: track the minimum and maximum accepted die value per instruction. result[22:16] = max die, result[29:23] = min die. Both are 0 on error.
- When undefined: result[30:16]=0 and the tracking registers are absent.

Decomposition:
- Shared package dice_pkg holds:
  - die-code localparams (DIE_D4..DIE_D100, DIE_INVALID);
  - faces and mask lookup functions;
  - FSM state typedef;
  - result bit-field position constants.
- One sub-module, rng_bit_sipo: RAND_W-bit MSB-first shifter with count, clear and sample_ready. The FSM and accumulator remain in dice_multi_roll.

Test Plan:
- D6 with rejection: dataa=0x11, datab=0; bits 0000111 (v=7, rejected) then 0000010 (v=2) → result=3, done once, o_stop low only during COLLECT/CHECK.
- 3×D20: dataa=0x35; bit groups 0000000, 0010011, 0000100 → dice 1, 20, 5 → result=26 (0x1A). With DICE_ROLL_STATS_EN: max=20, min=1.
- Invalid inputs: dataa=0x1F, then dataa=0x01 (count=0), then dataa=0x95 with MAX_DICE=8 → each gives result=0x8000_0000, done at start+1, no bits consumed.
- Modifier clamp:
  - dataa=0x10 (1×D4), datab=0xFE; bits 0000000 → die=1, 1−2 → result=0.
  - datab=0x05, same bits → result=6.
- Stalls and reset:
  - clk_en=0 for 10 cycles mid-COLLECT → bit count unchanged, final result matches the unstalled run.
  - i_rand_valid gaps → same result.
  - reset_n low mid-COLLECT → done never pulses; result=0 and o_stop=1 immediately.
- Busy start: second start with dataa=0x06 during COLLECT of a D6 roll → ignored; the original roll completes with the D6 result and exactly one done.
